// File: rtl/memory_map_router.sv
// Address decoder and data router between the core data port and six memory-mapped devices.
// Writes are steered combinationally; read data returns one clock later from the registered select.
module memory_map_router #(
   parameter int          DATA_W     = 32,
   parameter logic [15:0] DM_BASE    = 16'h0000,
   parameter logic [15:0] INTC_BASE  = 16'h0001,
   parameter logic [15:0] FACT0_BASE = 16'h0002,
   parameter logic [15:0] FACT1_BASE = 16'h0003,
   parameter logic [15:0] FACT2_BASE = 16'h0004,
   parameter logic [15:0] FACT3_BASE = 16'h0005
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_enable,
   input  logic [31:0]       input_addr,
   input  logic [DATA_W-1:0] input_data,
   output logic [DATA_W-1:0] output_data,
   output logic              data_valid,

   input  logic [DATA_W-1:0] dm_rdata,
   output logic              dm_we,
   output logic [31:0]       dm_addr,
   output logic [DATA_W-1:0] dm_wdata,

   input  logic [DATA_W-1:0] intc_rdata,
   output logic              intc_we,
   output logic [31:0]       intc_addr,
   output logic [DATA_W-1:0] intc_wdata,

   input  logic [DATA_W-1:0] fact0_rdata,
   output logic              fact0_we,
   output logic [31:0]       fact0_addr,
   output logic [DATA_W-1:0] fact0_wdata,

   input  logic [DATA_W-1:0] fact1_rdata,
   output logic              fact1_we,
   output logic [31:0]       fact1_addr,
   output logic [DATA_W-1:0] fact1_wdata,

   input  logic [DATA_W-1:0] fact2_rdata,
   output logic              fact2_we,
   output logic [31:0]       fact2_addr,
   output logic [DATA_W-1:0] fact2_wdata,

   input  logic [DATA_W-1:0] fact3_rdata,
   output logic              fact3_we,
   output logic [31:0]       fact3_addr,
   output logic [DATA_W-1:0] fact3_wdata
);

   typedef enum logic [2:0] {
      SEL_DM    = 3'd0,
      SEL_INTC  = 3'd1,
      SEL_FACT0 = 3'd2,
      SEL_FACT1 = 3'd3,
      SEL_FACT2 = 3'd4,
      SEL_FACT3 = 3'd5,
      SEL_NONE  = 3'd7
   } sel_t;

   logic [15:0] region_tag;
   logic [31:0] local_addr;
   sel_t        sel_p0;
   logic        mapped_p0;
   logic        wr_gate;
   sel_t        sel_p1;
   logic        vld_p1;

   assign region_tag = input_addr[31:16];
   assign local_addr = {16'h0000, input_addr[15:0]};

   // Stage p0: combinational decode of the region tag
   always_comb begin
      sel_p0 = SEL_NONE;
      if (region_tag == DM_BASE)         sel_p0 = SEL_DM;
      else if (region_tag == INTC_BASE)  sel_p0 = SEL_INTC;
      else if (region_tag == FACT0_BASE) sel_p0 = SEL_FACT0;
      else if (region_tag == FACT1_BASE) sel_p0 = SEL_FACT1;
      else if (region_tag == FACT2_BASE) sel_p0 = SEL_FACT2;
      else if (region_tag == FACT3_BASE) sel_p0 = SEL_FACT3;
   end

   assign mapped_p0 = (sel_p0 != SEL_NONE);
   assign wr_gate   = write_enable & ~rst;

   assign dm_we    = wr_gate & (sel_p0 == SEL_DM);
   assign intc_we  = wr_gate & (sel_p0 == SEL_INTC);
   assign fact0_we = wr_gate & (sel_p0 == SEL_FACT0);
   assign fact1_we = wr_gate & (sel_p0 == SEL_FACT1);
   assign fact2_we = wr_gate & (sel_p0 == SEL_FACT2);
   assign fact3_we = wr_gate & (sel_p0 == SEL_FACT3);

   // Offset and write data are broadcast; only the strobe distinguishes the target
   assign dm_addr    = local_addr;
   assign intc_addr  = local_addr;
   assign fact0_addr = local_addr;
   assign fact1_addr = local_addr;
   assign fact2_addr = local_addr;
   assign fact3_addr = local_addr;

   assign dm_wdata    = input_data;
   assign intc_wdata  = input_data;
   assign fact0_wdata = input_data;
   assign fact1_wdata = input_data;
   assign fact2_wdata = input_data;
   assign fact3_wdata = input_data;

   // Stage p1: select registered to line up with the devices' synchronous read
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_p1 <= SEL_NONE;
         vld_p1 <= 1'b0;
      end else begin
         sel_p1 <= sel_p0;
         vld_p1 <= mapped_p0 & ~write_enable;
      end
   end

   always_comb begin
      output_data = '0;
      case (sel_p1)
         SEL_DM:    output_data = dm_rdata;
         SEL_INTC:  output_data = intc_rdata;
         SEL_FACT0: output_data = fact0_rdata;
         SEL_FACT1: output_data = fact1_rdata;
         SEL_FACT2: output_data = fact2_rdata;
         SEL_FACT3: output_data = fact3_rdata;
         default:   output_data = '0;
      endcase
   end

   assign data_valid = vld_p1;

endmodule

// File: tb/tb_memory_map_router.sv
// Bench for memory_map_router: table of vectors plus hand-written reset sequences,
// with read results tracked through a scoreboard queue.
module tb_memory_map_router;

   localparam logic [31:0] RD_DM    = 32'hDDDD_0001;
   localparam logic [31:0] RD_INTC  = 32'h1C1C_0002;
   localparam logic [31:0] RD_FACT0 = 32'hF0F0_0003;
   localparam logic [31:0] RD_FACT1 = 32'hF1F1_0004;
   localparam logic [31:0] RD_FACT2 = 32'h0000_1234;
   localparam logic [31:0] RD_FACT3 = 32'hF3F3_0006;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_enable;
   logic [31:0] input_addr;
   logic [31:0] input_data;
   logic [31:0] output_data;
   logic        data_valid;

   logic [31:0] dm_rdata, intc_rdata, fact0_rdata, fact1_rdata, fact2_rdata, fact3_rdata;
   logic        dm_we, intc_we, fact0_we, fact1_we, fact2_we, fact3_we;
   logic [31:0] dm_addr, intc_addr, fact0_addr, fact1_addr, fact2_addr, fact3_addr;
   logic [31:0] dm_wdata, intc_wdata, fact0_wdata, fact1_wdata, fact2_wdata, fact3_wdata;

   logic [5:0]  we_vec;
   logic [31:0] addr_arr  [6];
   logic [31:0] wdata_arr [6];

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } rd_exp_t;
   rd_exp_t sb_q [$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [5:0]  exp_we;
      logic        exp_valid;
      logic [31:0] exp_out;
   } vec_t;
   vec_t vecs [16];

   always #5 clk = ~clk;

   assign dm_rdata    = RD_DM;
   assign intc_rdata  = RD_INTC;
   assign fact0_rdata = RD_FACT0;
   assign fact1_rdata = RD_FACT1;
   assign fact2_rdata = RD_FACT2;
   assign fact3_rdata = RD_FACT3;

   assign we_vec = {fact3_we, fact2_we, fact1_we, fact0_we, intc_we, dm_we};
   assign addr_arr[0] = dm_addr;    assign wdata_arr[0] = dm_wdata;
   assign addr_arr[1] = intc_addr;  assign wdata_arr[1] = intc_wdata;
   assign addr_arr[2] = fact0_addr; assign wdata_arr[2] = fact0_wdata;
   assign addr_arr[3] = fact1_addr; assign wdata_arr[3] = fact1_wdata;
   assign addr_arr[4] = fact2_addr; assign wdata_arr[4] = fact2_wdata;
   assign addr_arr[5] = fact3_addr; assign wdata_arr[5] = fact3_wdata;

   memory_map_router dut (
      .clk(clk), .rst(rst), .write_enable(write_enable),
      .input_addr(input_addr), .input_data(input_data),
      .output_data(output_data), .data_valid(data_valid),
      .dm_rdata(dm_rdata), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .intc_rdata(intc_rdata), .intc_we(intc_we), .intc_addr(intc_addr), .intc_wdata(intc_wdata),
      .fact0_rdata(fact0_rdata), .fact0_we(fact0_we), .fact0_addr(fact0_addr), .fact0_wdata(fact0_wdata),
      .fact1_rdata(fact1_rdata), .fact1_we(fact1_we), .fact1_addr(fact1_addr), .fact1_wdata(fact1_wdata),
      .fact2_rdata(fact2_rdata), .fact2_we(fact2_we), .fact2_addr(fact2_addr), .fact2_wdata(fact2_wdata),
      .fact3_rdata(fact3_rdata), .fact3_we(fact3_we), .fact3_addr(fact3_addr), .fact3_wdata(fact3_wdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, then check the read result after the edge
   task automatic step(input string tag, input logic r, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [5:0] exp_we,
                       input logic exp_valid, input logic [31:0] exp_out);
      rd_exp_t e;
      @(negedge clk);
      rst = r;
      write_enable = we;
      input_addr = addr;
      input_data = wdata;
      #1;
      check({tag, " we"}, {26'h0, we_vec}, {26'h0, exp_we});
      for (int d = 0; d < 6; d++) begin
         check($sformatf("%s addr[%0d]", tag, d), addr_arr[d], {16'h0, addr[15:0]});
         check($sformatf("%s wdata[%0d]", tag, d), wdata_arr[d], wdata);
      end
      sb_q.push_back('{valid: exp_valid, data: exp_out});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'h1, 32'h0);
      end else begin
         e = sb_q.pop_front();
         check({tag, " data_valid"}, {31'h0, data_valid}, {31'h0, e.valid});
         check({tag, " output_data"}, output_data, e.data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_000A, 6'h00, 1'b1, RD_DM};
      vecs[1]  = '{1'b1, 32'h0000_0000, 32'h0000_000A, 6'h01, 1'b0, RD_DM};
      vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_000A, 6'h00, 1'b1, RD_DM};
      vecs[3]  = '{1'b1, 32'h0001_0000, 32'h0000_000B, 6'h02, 1'b0, RD_INTC};
      vecs[4]  = '{1'b1, 32'h0002_0000, 32'h0000_000C, 6'h04, 1'b0, RD_FACT0};
      vecs[5]  = '{1'b1, 32'h0003_0000, 32'h0000_000D, 6'h08, 1'b0, RD_FACT1};
      vecs[6]  = '{1'b0, 32'h0004_0008, 32'h0000_0000, 6'h00, 1'b1, RD_FACT2};
      vecs[7]  = '{1'b1, 32'h0009_0000, 32'h5555_AAAA, 6'h00, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 32'h0002_FFFF, 32'hCAFE_F00D, 6'h04, 1'b0, RD_FACT0};
      vecs[9]  = '{1'b0, 32'h0005_FFFF, 32'h0000_0000, 6'h00, 1'b1, RD_FACT3};
      vecs[10] = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 6'h00, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 32'h0005_0010, 32'h1357_9BDF, 6'h20, 1'b0, RD_FACT3};
      vecs[12] = '{1'b0, 32'h0001_0004, 32'h0000_0000, 6'h00, 1'b1, RD_INTC};
      vecs[13] = '{1'b0, 32'h0006_0000, 32'h0000_0000, 6'h00, 1'b0, 32'h0};
      vecs[14] = '{1'b1, 32'h0004_0000, 32'hDEAD_BEEF, 6'h10, 1'b0, RD_FACT2};
      vecs[15] = '{1'b0, 32'h0003_0000, 32'h0000_0000, 6'h00, 1'b1, RD_FACT1};

      rst = 1'b1;
      write_enable = 1'b0;
      input_addr = 32'h0;
      input_data = 32'h0;

      // Reset with a pending write to DM: strobe gated, read path cleared
      step("reset", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_000A, 6'h00, 1'b0, 32'h0);
      step("reset2", 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 6'h00, 1'b0, 32'h0);

      for (int i = 0; i < 16; i++)
         step($sformatf("vec%0d", i), 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_we, vecs[i].exp_valid, vecs[i].exp_out);

      // Reset arriving during a read drops it, then normal operation resumes
      step("pre_rst_rd", 1'b0, 1'b0, 32'h0000_0000, 32'h0, 6'h00, 1'b1, RD_DM);
      step("mid_rst_rd", 1'b1, 1'b0, 32'h0004_0008, 32'h0, 6'h00, 1'b0, 32'h0);
      step("mid_rst_wr", 1'b1, 1'b1, 32'h0003_0008, 32'h77, 6'h00, 1'b0, 32'h0);
      step("post_rst_rd", 1'b0, 1'b0, 32'h0004_0008, 32'h0, 6'h00, 1'b1, RD_FACT2);
      step("post_rst_wr", 1'b0, 1'b1, 32'h0000_0004, 32'h99, 6'h01, 1'b0, RD_DM);

      check("scoreboard drained", sb_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
